// File: rtl/alu_pkg.sv
// Shared constants and types for the LC3 execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_SL  = 4'b0110;
  localparam logic [3:0] ALU_SR  = 4'b0111;

  localparam logic [2:0] NZP_RST = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative MUL (shift-add, LSB first) and one-bit-per-cycle shift engine.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             launch_i,
  input  logic             mul_i,
  input  logic             left_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       amount_i,
  output logic             busy_o,
  output logic             fin_c,
  output logic [WIDTH-1:0] res_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             left_q;

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] shift_d;

  // Next accumulator / shifted operand; the final step's value is the result.
  always_comb begin
    acc_d   = acc_q + (opb_q[0] ? opa_q : '0);
    shift_d = left_q ? {opa_q[WIDTH-2:0], 1'b0} : {1'b0, opa_q[WIDTH-1:1]};
  end

  assign busy_o = (state_q != ST_IDLE);
  assign fin_c  = (state_q != ST_IDLE) && (cnt_q == CNT_W'(1));
  assign res_c  = (state_q == ST_MUL) ? acc_d : shift_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      left_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch_i) begin
            opa_q <= a_i;
            if (mul_i) begin
              state_q <= ST_MUL;
              cnt_q   <= CNT_W'(WIDTH);
              acc_q   <= '0;
              opb_q   <= b_i;
            end else begin
              state_q <= ST_SHIFT;
              cnt_q   <= CNT_W'(amount_i);
              left_q  <= left_i;
            end
          end
        end
        ST_MUL: begin
          acc_q <= acc_d;
          opa_q <= {opa_q[WIDTH-2:0], 1'b0};
          opb_q <= {1'b0, opb_q[WIDTH-1:1]};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_IDLE;
        end
        ST_SHIFT: begin
          opa_q <= shift_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_execute.sv
// LC3 execute-stage ALU: single-cycle ADD/AND/NOT, iterative MUL/SL/SR,
// START/BUSY/DONE handshake with registered RESULT and condition codes.
module alu_execute
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       ALU_CONTROL,
  input  logic             IS_IMMEDIATE,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  input  logic [4:0]       IMM5,
  output logic [WIDTH-1:0] RESULT,
  output logic [2:0]       NZP,
  output logic             BUSY,
  output logic             DONE,
  output logic             ILLEGAL
);

  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       nzp_q, nzp_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] op_b;
  logic             launch;
  logic             iter_go;
  logic             iter_busy;
  logic             iter_fin;
  logic [WIDTH-1:0] iter_res;
  logic             wr;
  logic [WIDTH-1:0] wr_val;

  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
    if (v == '0)          return 3'b010;
    else if (v[WIDTH-1])  return 3'b100;
    else                  return 3'b001;
  endfunction

  assign op_b   = IS_IMMEDIATE ? {{(WIDTH-5){IMM5[4]}}, IMM5} : SRC_B;
  assign launch = START && !iter_busy;

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (CLK),
    .rst      (RESET),
    .launch_i (iter_go),
    .mul_i    (ALU_CONTROL == ALU_MUL),
    .left_i   (ALU_CONTROL == ALU_SL),
    .a_i      (SRC_A),
    .b_i      (op_b),
    .amount_i (op_b[3:0]),
    .busy_o   (iter_busy),
    .fin_c    (iter_fin),
    .res_c    (iter_res)
  );

  // Launch decode, iterative completion and result/flag write-back.
  always_comb begin
    result_d  = result_q;
    nzp_d     = nzp_q;
    done_d    = 1'b0;
    illegal_d = illegal_q;
    iter_go   = 1'b0;
    wr        = 1'b0;
    wr_val    = '0;
    if (iter_fin) begin
      wr     = 1'b1;
      wr_val = iter_res;
    end else if (launch) begin
      illegal_d = 1'b0;
      case (ALU_CONTROL)
        ALU_ADD: begin wr = 1'b1; wr_val = SRC_A + op_b; end
        ALU_AND: begin wr = 1'b1; wr_val = SRC_A & op_b; end
        ALU_NOT: begin wr = 1'b1; wr_val = ~SRC_A;       end
        ALU_MUL: iter_go = 1'b1;
        ALU_SL, ALU_SR: begin
          if (op_b[3:0] == 4'd0) begin
            wr     = 1'b1;
            wr_val = SRC_A;
          end else begin
            iter_go = 1'b1;
          end
        end
        default: begin
          illegal_d = 1'b1;
          done_d    = 1'b1;
        end
      endcase
    end
    if (wr) begin
      result_d = wr_val;
      nzp_d    = nzp_of(wr_val);
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      result_q  <= '0;
      nzp_q     <= NZP_RST;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      nzp_q     <= nzp_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign RESULT  = result_q;
  assign NZP     = nzp_q;
  assign BUSY    = iter_busy;
  assign DONE    = done_q;
  assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_alu_execute.sv
// Self-checking bench for alu_execute: directed table, corner sequences, random vs model.
module tb_alu_execute;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [3:0]  ALU_CONTROL;
  logic        IS_IMMEDIATE;
  logic [15:0] SRC_A;
  logic [15:0] SRC_B;
  logic [4:0]  IMM5;
  logic [15:0] RESULT;
  logic [2:0]  NZP;
  logic        BUSY;
  logic        DONE;
  logic        ILLEGAL;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_result;
  logic [2:0]  m_nzp;

  alu_execute #(.WIDTH(16)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .START        (START),
    .ALU_CONTROL  (ALU_CONTROL),
    .IS_IMMEDIATE (IS_IMMEDIATE),
    .SRC_A        (SRC_A),
    .SRC_B        (SRC_B),
    .IMM5         (IMM5),
    .RESULT       (RESULT),
    .NZP          (NZP),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ILLEGAL      (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  imm;
    logic        isimm;
    logic [15:0] res;
    logic [2:0]  nzp;
    logic        ill;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_nzp(input logic [15:0] v);
    if (v == 16'h0) return 3'b010;
    if ($signed(v) < 0) return 3'b100;
    return 3'b001;
  endfunction

  // Reference behaviour from the arithmetic rules, independent of iteration detail.
  task automatic model(input logic [3:0] code, input logic [15:0] a, input logic [15:0] srcb,
                       input logic [4:0] imm, input logic isimm,
                       output logic [15:0] res, output logic [2:0] nzp,
                       output logic ill, output int lat);
    int unsigned b, amt, prod;
    b   = isimm ? ((32'(imm) ^ 32'h10) - 32'h10) & 32'hFFFF : 32'(srcb);
    amt = b % 16;
    ill = 1'b0;
    lat = 0;
    res = m_result;
    case (code)
      4'd0: res = 16'((32'(a) + b) % 65536);
      4'd1: res = a & 16'(b);
      4'd4: res = 16'hFFFF - a;
      4'd5: begin prod = 32'(a) * b; res = 16'(prod % 65536); lat = 16; end
      4'd6: begin res = 16'((32'(a) * (32'd1 << amt)) % 65536); lat = int'(amt); end
      4'd7: begin res = 16'(32'(a) / (32'd1 << amt)); lat = int'(amt); end
      default: ill = 1'b1;
    endcase
    nzp = ill ? m_nzp : ref_nzp(res);
  endtask

  task automatic do_op(input string nm, input logic [3:0] code, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] imm, input logic isimm,
                       input logic [15:0] eres, input logic [2:0] enzp,
                       input logic eill, input int elat);
    int cyc;
    int busy_cnt;
    @(negedge CLK);
    ALU_CONTROL  = code;
    SRC_A        = a;
    SRC_B        = b;
    IMM5         = imm;
    IS_IMMEDIATE = isimm;
    START        = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    SRC_A = ~a;
    SRC_B = ~b;
    IMM5  = ~imm;
    cyc = 0;
    busy_cnt = 0;
    while (!DONE && cyc < 40) begin
      if (BUSY) busy_cnt++;
      @(negedge CLK);
      cyc++;
    end
    chk({nm, " done"}, 32'(DONE), 32'd1);
    chk({nm, " busy_with_done"}, 32'(BUSY), 32'd0);
    chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'(elat));
    chk({nm, " result"}, 32'(RESULT), 32'(eres));
    chk({nm, " nzp"}, 32'(NZP), 32'(enzp));
    chk({nm, " illegal"}, 32'(ILLEGAL), 32'(eill));
    m_result = eres;
    m_nzp    = enzp;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, " rst result"}, 32'(RESULT), 32'h0);
    chk({nm, " rst nzp"}, 32'(NZP), 32'b010);
    chk({nm, " rst busy"}, 32'(BUSY), 32'd0);
    chk({nm, " rst done"}, 32'(DONE), 32'd0);
    chk({nm, " rst illegal"}, 32'(ILLEGAL), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [15:0] er;
    logic [2:0]  en;
    logic        ei;
    int          el;
    logic [3:0]  code;
    logic [15:0] ra, rb;
    logic [4:0]  ri;
    logic        rim;
    int          idx;

    vecs[0] = '{4'h0, 16'h7FFF, 16'h0001, 5'h00, 1'b0, 16'h8000, 3'b100, 1'b0, 0};
    vecs[1] = '{4'h1, 16'h00FF, 16'h0000, 5'b10000, 1'b1, 16'h00F0, 3'b001, 1'b0, 0};
    vecs[2] = '{4'h5, 16'h0003, 16'hFFFE, 5'h00, 1'b0, 16'hFFFA, 3'b100, 1'b0, 16};
    vecs[3] = '{4'h6, 16'h0001, 16'h0004, 5'h00, 1'b0, 16'h0010, 3'b001, 1'b0, 4};
    vecs[4] = '{4'h7, 16'h8000, 16'h000F, 5'h00, 1'b0, 16'h0001, 3'b001, 1'b0, 15};
    vecs[5] = '{4'h7, 16'h1234, 16'h0000, 5'h00, 1'b0, 16'h1234, 3'b001, 1'b0, 0};
    vecs[6] = '{4'hF, 16'hAAAA, 16'h5555, 5'h00, 1'b0, 16'h1234, 3'b001, 1'b1, 0};
    vecs[7] = '{4'h4, 16'hFFFF, 16'h0000, 5'h00, 1'b0, 16'h0000, 3'b010, 1'b0, 0};
    vecs[8] = '{4'h0, 16'hFFFF, 16'h0001, 5'h00, 1'b0, 16'h0000, 3'b010, 1'b0, 0};
    vecs[9] = '{4'h6, 16'h8001, 16'hFFFF, 5'b00001, 1'b1, 16'h0002, 3'b001, 1'b0, 1};

    RESET = 1'b1;
    START = 1'b0;
    ALU_CONTROL = 4'h0;
    IS_IMMEDIATE = 1'b0;
    SRC_A = 16'h0;
    SRC_B = 16'h0;
    IMM5 = 5'h0;
    m_result = 16'h0;
    m_nzp = 3'b010;
    repeat (3) @(negedge CLK);
    check_reset_vals("init");
    RESET = 1'b0;

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].imm,
            vecs[i].isimm, vecs[i].res, vecs[i].nzp, vecs[i].ill, vecs[i].lat);

    // MUL with a START pulse and operand changes mid-operation.
    @(negedge CLK);
    ALU_CONTROL = 4'h5; SRC_A = 16'h0003; SRC_B = 16'hFFFE; IS_IMMEDIATE = 1'b0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    idx = 0;
    repeat (4) begin @(negedge CLK); idx++; end
    ALU_CONTROL = 4'h0; SRC_A = 16'h1111; SRC_B = 16'h2222; START = 1'b1;
    @(negedge CLK); idx++;
    START = 1'b0;
    while (!DONE && idx < 40) begin @(negedge CLK); idx++; end
    chk("mulstall done_index", 32'(idx), 32'd16);
    chk("mulstall result", 32'(RESULT), 32'hFFFA);
    chk("mulstall nzp", 32'(NZP), 32'b100);
    @(negedge CLK);
    chk("mulstall no_relaunch busy", 32'(BUSY), 32'd0);
    chk("mulstall no_relaunch done", 32'(DONE), 32'd0);
    m_result = 16'hFFFA;
    m_nzp = 3'b100;

    // Reset in the middle of a MUL.
    ALU_CONTROL = 4'h5; SRC_A = 16'h0007; SRC_B = 16'h0009; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    chk("midmul busy", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    #1;
    check_reset_vals("midmul");
    @(negedge CLK);
    RESET = 1'b0;
    m_result = 16'h0;
    m_nzp = 3'b010;
    do_op("post_reset add", 4'h0, 16'h0002, 16'h0003, 5'h0, 1'b0, 16'h0005, 3'b001, 1'b0, 0);

    // Random operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      idx = int'($urandom_range(0, 7));
      case (idx)
        0: code = 4'h0;
        1: code = 4'h1;
        2: code = 4'h4;
        3: code = 4'h5;
        4: code = 4'h6;
        5: code = 4'h7;
        default: code = 4'($urandom_range(8, 15));
      endcase
      if ($urandom_range(0, 9) == 0) code = 4'($urandom_range(2, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      ri  = 5'($urandom);
      rim = 1'($urandom);
      model(code, ra, rb, ri, rim, er, en, ei, el);
      do_op($sformatf("rnd%0d", n), code, ra, rb, ri, rim, er, en, ei, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
